// File: rtl/majority_vote_seq.sv
// majority_vote_seq: N-channel threshold voter with a hysteresis-filtered vote and a one-deep output register.
// Optional build macro MAJ_FAULT_TRACK_EN adds sticky per-channel disagreement flags (fault / fault_clr).
module majority_vote_seq #(
  parameter int N         = 5,
  parameter int THRESH    = 3,
  parameter int HOLD      = 2,
  parameter int FAULT_LIM = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               in_vec,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_raw,
  output logic                       out_vote,
  output logic [$clog2(N+1)-1:0]     out_cnt,
  output logic [N-1:0]               fault,
  input  logic                       fault_clr
);

  localparam int CW = $clog2(N+1);

  // Handshake: a sample moves on an edge where valid and ready are both 1. The output
  // register accepts a new sample whenever it is empty or being drained this cycle;
  // ready is forced low while reset is asserted.
  logic          accept;
  logic [CW-1:0] pop_cnt;
  logic          raw_vote;
  logic [3:0]    hold_cnt;
  logic [3:0]    hold_cnt_nxt;
  logic          vote_nxt;

  assign in_ready = rst_n & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < N; i++) begin
      pop_cnt = pop_cnt + CW'(in_vec[i]);
    end
  end

  assign raw_vote = (32'(pop_cnt) >= 32'(THRESH));

  // Filtered vote flips only after HOLD consecutive accepted samples that disagree with it.
  always_comb begin
    hold_cnt_nxt = hold_cnt;
    vote_nxt     = out_vote;
    if (accept) begin
      if (raw_vote == out_vote) begin
        hold_cnt_nxt = '0;
      end else if (hold_cnt == 4'(HOLD - 1)) begin
        vote_nxt     = ~out_vote;
        hold_cnt_nxt = '0;
      end else begin
        hold_cnt_nxt = hold_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_raw   <= 1'b0;
      out_vote  <= 1'b0;
      out_cnt   <= '0;
      hold_cnt  <= '0;
    end else begin
      out_vote <= vote_nxt;
      hold_cnt <= hold_cnt_nxt;
      if (accept) begin
        out_valid <= 1'b1;
        out_raw   <= raw_vote;
        out_cnt   <= pop_cnt;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef MAJ_FAULT_TRACK_EN
  localparam int DW = 8;

  logic [DW-1:0] dis_cnt [N];

  // Clear takes priority over a simultaneous accept, so that sample is never counted.
  always_ff @(posedge clk) begin
    if (!rst_n || fault_clr) begin
      fault <= '0;
      for (int i = 0; i < N; i++) begin
        dis_cnt[i] <= '0;
      end
    end else if (accept) begin
      for (int i = 0; i < N; i++) begin
        if (in_vec[i] != raw_vote) begin
          if (dis_cnt[i] != DW'(FAULT_LIM)) begin
            dis_cnt[i] <= dis_cnt[i] + 8'd1;
          end
          if (dis_cnt[i] >= DW'(FAULT_LIM - 1)) begin
            fault[i] <= 1'b1;
          end
        end else begin
          dis_cnt[i] <= '0;
        end
      end
    end
  end
`else
  logic unused_fault_clr;

  assign unused_fault_clr = fault_clr;
  assign fault            = '0;
`endif

endmodule

// File: tb/tb_majority_vote_seq.sv
// Bench for majority_vote_seq: default instance plus an N=7/THRESH=4 instance, checked every cycle
// against a transaction-level model, a result scoreboard, and directed literal expectations.
module tb_majority_vote_seq;

  localparam int N         = 5;
  localparam int N7        = 7;
  localparam int HOLD      = 2;
  localparam int FAULT_LIM = 4;
  localparam int W         = 5;
  localparam int M_N  [2]  = '{5, 7};
  localparam int M_TH [2]  = '{3, 4};

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          in_valid;
  logic          out_ready;
  logic          fault_clr;
  logic [N-1:0]  in_vec;
  logic          in_ready;
  logic          out_valid;
  logic          out_raw;
  logic          out_vote;
  logic [2:0]    out_cnt;
  logic [N-1:0]  fault;

  logic          in_valid7;
  logic          out_ready7;
  logic [N7-1:0] in_vec7;
  logic          in_ready7;
  logic          out_valid7;
  logic          out_raw7;
  logic          out_vote7;
  logic [2:0]    out_cnt7;
  logic [N7-1:0] fault7;

  majority_vote_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec),
    .out_valid(out_valid), .out_ready(out_ready), .out_raw(out_raw), .out_vote(out_vote),
    .out_cnt(out_cnt), .fault(fault), .fault_clr(fault_clr)
  );

  majority_vote_seq #(.N(7), .THRESH(4)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7), .in_vec(in_vec7),
    .out_valid(out_valid7), .out_ready(out_ready7), .out_raw(out_raw7), .out_vote(out_vote7),
    .out_cnt(out_cnt7), .fault(fault7), .fault_clr(fault_clr)
  );

  int vectors    = 0;
  int miscompares = 0;

  // behavioural model, one slot per instance
  logic          m_valid [2];
  logic          m_raw   [2];
  logic          m_vote  [2];
  int            m_cnt   [2];
  int            m_run   [2];
  int            m_dis   [2][N7];
  logic [N7-1:0] m_fault [2];

  // scoreboard of delivered results for the default instance: {raw, vote, cnt}
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_update(input int k, input logic r, input logic v, input logic [N7-1:0] vec,
                              input logic ordy, input logic fc, output logic acc);
    int pc;
    acc = r & v & (~m_valid[k] | ordy);
    if (!r) begin
      m_valid[k] = 1'b0;
      m_raw[k]   = 1'b0;
      m_vote[k]  = 1'b0;
      m_cnt[k]   = 0;
      m_run[k]   = 0;
      m_fault[k] = '0;
      for (int i = 0; i < N7; i++) m_dis[k][i] = 0;
    end else begin
      if (acc) begin
        pc = 0;
        for (int i = 0; i < M_N[k]; i++) pc += int'(vec[i]);
        m_cnt[k] = pc;
        m_raw[k] = (pc >= M_TH[k]);
        if (m_raw[k] == m_vote[k]) begin
          m_run[k] = 0;
        end else begin
          m_run[k]++;
          if (m_run[k] == HOLD) begin
            m_vote[k] = ~m_vote[k];
            m_run[k]  = 0;
          end
        end
        m_valid[k] = 1'b1;
      end else if (ordy) begin
        m_valid[k] = 1'b0;
      end
`ifdef MAJ_FAULT_TRACK_EN
      if (fc) begin
        m_fault[k] = '0;
        for (int i = 0; i < N7; i++) m_dis[k][i] = 0;
      end else if (acc) begin
        for (int i = 0; i < M_N[k]; i++) begin
          if (vec[i] != m_raw[k]) begin
            if (m_dis[k][i] < FAULT_LIM) m_dis[k][i]++;
          end else begin
            m_dis[k][i] = 0;
          end
          if (m_dis[k][i] == FAULT_LIM) m_fault[k][i] = 1'b1;
        end
      end
`else
      if (fc && 1'b0) m_fault[k] = '1;
`endif
    end
  endtask

  task automatic compare_all();
    chk("out_valid", 32'(out_valid), 32'(m_valid[0]));
    chk("out_raw", 32'(out_raw), 32'(m_raw[0]));
    chk("out_vote", 32'(out_vote), 32'(m_vote[0]));
    chk("out_cnt", 32'(out_cnt), m_cnt[0]);
    chk("fault", 32'(fault), 32'(m_fault[0][N-1:0]));
    chk("out_valid7", 32'(out_valid7), 32'(m_valid[1]));
    chk("out_raw7", 32'(out_raw7), 32'(m_raw[1]));
    chk("out_vote7", 32'(out_vote7), 32'(m_vote[1]));
    chk("out_cnt7", 32'(out_cnt7), m_cnt[1]);
    chk("fault7", 32'(fault7), 32'(m_fault[1]));
  endtask

  // driver: one clock cycle; dut7 inputs come from in_valid7 / in_vec7 / out_ready7
  task automatic step(input logic r, input logic v, input logic [N-1:0] vec, input logic ordy,
                      input logic fc);
    logic         acc0;
    logic         acc1;
    logic [W-1:0] exp;
    rst_n     = r;
    in_valid  = v;
    in_vec    = vec;
    out_ready = ordy;
    fault_clr = fc;
    #1;
    chk("in_ready", 32'(in_ready), 32'(r & (~m_valid[0] | ordy)));
    chk("in_ready7", 32'(in_ready7), 32'(r & (~m_valid[1] | out_ready7)));
    if (r && out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL sb_empty: got a result handshake, expected none pending (t=%0t)", $time);
      end else begin
        exp = exp_q.pop_front();
        chk("sb_result", 32'({out_raw, out_vote, out_cnt}), 32'(exp));
      end
    end
    model_update(0, r, v, 7'(vec), ordy, fc, acc0);
    model_update(1, r, in_valid7, in_vec7, out_ready7, fc, acc1);
    if (!r) exp_q.delete();
    else if (acc0) exp_q.push_back({m_raw[0], m_vote[0], 3'(m_cnt[0])});
    @(posedge clk);
    #1;
    compare_all();
  endtask

  logic [N-1:0] rv;
  int           p;

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_valid[k] = 1'b0; m_raw[k] = 1'b0; m_vote[k] = 1'b0;
      m_cnt[k] = 0; m_run[k] = 0; m_fault[k] = '0;
      for (int i = 0; i < N7; i++) m_dis[k][i] = 0;
    end
    in_valid7  = 1'b0;
    in_vec7    = '0;
    out_ready7 = 1'b1;

    // reset state
    step(1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_cnt", 32'(out_cnt), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);

    // basic vote and hold
    step(1'b1, 1'b1, 5'b00111, 1'b1, 1'b0);
    chk("d1_cnt", 32'(out_cnt), 32'd3);
    chk("d1_raw", 32'(out_raw), 32'd1);
    chk("d1_vote", 32'(out_vote), 32'd0);
    step(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0);
    chk("d2_vote", 32'(out_vote), 32'd1);

    // agreeing sample restarts the filter
    step(1'b1, 1'b1, 5'b00011, 1'b1, 1'b0);
    chk("d3_vote_a", 32'(out_vote), 32'd1);
    step(1'b1, 1'b1, 5'b11111, 1'b1, 1'b0);
    chk("d3_vote_b", 32'(out_vote), 32'd1);
    step(1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
    chk("d3_vote_c", 32'(out_vote), 32'd1);
    step(1'b1, 1'b0, 5'b0, 1'b1, 1'b0);
    chk("d3_idle_valid", 32'(out_valid), 32'd0);

    // backpressure: three stalled cycles then release
    step(1'b1, 1'b1, 5'b11000, 1'b1, 1'b0);
    chk("d4_a_vote", 32'(out_vote), 32'd0);
    for (int c = 0; c < 3; c++) begin
      step(1'b1, 1'b1, 5'b11110, 1'b0, 1'b0);
      chk("d4_stall_ready", 32'(in_ready), 32'd0);
      chk("d4_stall_cnt", 32'(out_cnt), 32'd2);
    end
    step(1'b1, 1'b1, 5'b11110, 1'b1, 1'b0);
    chk("d4_b_cnt", 32'(out_cnt), 32'd4);
    chk("d4_b_raw", 32'(out_raw), 32'd1);
    step(1'b1, 1'b0, 5'b0, 1'b1, 1'b0);

    // stuck channel 0 and fault clear
    step(1'b1, 1'b0, 5'b0, 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
    chk("d5_fault_3", 32'(fault), 32'd0);
    step(1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
`ifdef MAJ_FAULT_TRACK_EN
    chk("d5_fault_4", 32'(fault), 32'b00001);
`else
    chk("d5_fault_4", 32'(fault), 32'd0);
`endif
    step(1'b1, 1'b1, 5'b00001, 1'b1, 1'b1);
    chk("d5_clr", 32'(fault), 32'd0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b1, 5'b00001, 1'b1, 1'b0);
    chk("d5_after_clr", 32'(fault), 32'd0);

    // reset during a stall
    step(1'b1, 1'b1, 5'b11111, 1'b1, 1'b0);
    step(1'b1, 1'b1, 5'b00000, 1'b0, 1'b0);
    chk("d6_pending", 32'(out_valid), 32'd1);
    step(1'b0, 1'b0, 5'b0, 1'b0, 1'b0);
    chk("d6_valid", 32'(out_valid), 32'd0);
    chk("d6_outs", 32'({out_raw, out_vote, out_cnt}), 32'd0);
    chk("d6_ready", 32'(in_ready), 32'd0);
    step(1'b1, 1'b1, 5'b00111, 1'b1, 1'b0);
    chk("d6_cnt", 32'(out_cnt), 32'd3);
    chk("d6_vote", 32'(out_vote), 32'd0);
    step(1'b1, 1'b1, 5'b10101, 1'b1, 1'b0);
    chk("d6_vote2", 32'(out_vote), 32'd1);

    // wider instance, higher threshold
    in_valid7 = 1'b1;
    in_vec7   = 7'b0001111;
    step(1'b1, 1'b0, 5'b0, 1'b1, 1'b0);
    chk("d7_raw", 32'(out_raw7), 32'd1);
    chk("d7_cnt", 32'(out_cnt7), 32'd4);
    in_vec7 = 7'b0000111;
    step(1'b1, 1'b0, 5'b0, 1'b1, 1'b0);
    chk("d7_raw2", 32'(out_raw7), 32'd0);
    chk("d7_cnt2", 32'(out_cnt7), 32'd3);
    chk("d7_fault", 32'(fault7), 32'd0);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      p = $urandom_range(0, 3);
      case (p)
        0, 1:    rv = 5'($urandom);
        2:       rv = 5'b00001;
        default: rv = 5'b11110;
      endcase
      in_valid7  = ($urandom_range(0, 9) < 7);
      in_vec7    = 7'($urandom);
      out_ready7 = ($urandom_range(0, 9) < 6);
      step(($urandom_range(0, 99) != 0), ($urandom_range(0, 9) < 7), rv,
           ($urandom_range(0, 9) < 6), ($urandom_range(0, 29) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
